// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron training engine.
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        UPDATE,
        EPOCH_END,
        DONE
    } state_t;

    localparam logic [1:0] T_POS = 2'b01;
    localparam logic [1:0] T_NEG = 2'b11;

    // Accumulator width: bias plus N_IN products can never overflow this.
    function automatic int acc_width(input int weight_w, input int data_w, input int n_in);
        return weight_w + data_w + $clog2(n_in + 1);
    endfunction

endpackage

// File: rtl/perceptron_mac.sv
// Sequential multiply-accumulate: clear preloads acc with w (the bias), en adds w*x.
module perceptron_mac #(
    parameter int WEIGHT_W = 14,
    parameter int DATA_W   = 7,
    parameter int ACC_W    = 23
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       en,
    input  logic signed [WEIGHT_W-1:0] w,
    input  logic signed [DATA_W-1:0]   x,
    output logic signed [ACC_W-1:0]    acc
);

    localparam int PROD_W = WEIGHT_W + DATA_W;

    logic signed [PROD_W-1:0] prod;

    assign prod = $signed({{DATA_W{w[WEIGHT_W-1]}}, w}) * $signed({{WEIGHT_W{x[DATA_W-1]}}, x});

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= {{(ACC_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
        end else if (en) begin
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// N-input perceptron training engine: fetches samples, runs one shared MAC, applies the perceptron rule.
// Build option PERCEPTRON_SAT_EN: saturating weight/bias updates; a saturated run never reports converged.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int DATA_W     = 7,
    parameter int WEIGHT_W   = 14,
    parameter int ETA_SHIFT  = 0,
    parameter int MAX_EPOCHS = 64,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           n_samples,
    input  logic [N_IN*DATA_W-1:0]     x_in,
    input  logic [1:0]                 t_in,
    input  logic                       data_valid,
    output logic                       data_req,
    output logic [CNT_W-1:0]           sample_idx,
    output logic                       done,
    output logic                       converged,
    output logic [7:0]                 epoch_count,
    output logic [N_IN*WEIGHT_W-1:0]   w_out,
    output logic [WEIGHT_W-1:0]        b_out
);

    localparam int ACC_W = acc_width(WEIGHT_W, DATA_W, N_IN);
    localparam int K_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_IN - 1);

    state_t state_reg, state_next;

    logic [CNT_W-1:0]           n_reg;
    logic [CNT_W-1:0]           idx_reg;
    logic [K_W-1:0]             k_reg;
    logic signed [DATA_W-1:0]   x_reg [N_IN];
    logic                       t_neg_reg;
    logic signed [WEIGHT_W-1:0] w_reg [N_IN];
    logic signed [WEIGHT_W-1:0] w_next [N_IN];
    logic signed [WEIGHT_W-1:0] b_reg;
    logic signed [WEIGHT_W-1:0] b_next;
    logic                       upd_reg;
    logic                       conv_reg;
    logic [7:0]                 epoch_reg;

    logic                       mac_clear;
    logic                       mac_en;
    logic signed [WEIGHT_W-1:0] mac_w;
    logic signed [ACC_W-1:0]    acc;

    logic                       more_samples;
    logic [7:0]                 epoch_inc;
    logic                       epoch_limit;
    logic                       acc_pos;
    logic                       mismatch;
    logic                       t_mag_unused;

    // Only the sign bit of the target matters; the magnitude bit is ignored.
    assign t_mag_unused = t_in[0];

    assign more_samples = ({1'b0, idx_reg} + (CNT_W+1)'(1)) < {1'b0, n_reg};
    assign epoch_inc    = epoch_reg + 8'd1;
    assign epoch_limit  = (epoch_inc == 8'(MAX_EPOCHS));
    // net == 0 classifies as -1, so only a strictly positive sum predicts +1.
    assign acc_pos      = !acc[ACC_W-1] && (acc != '0);
    assign mismatch     = (acc_pos == t_neg_reg);

    assign mac_w = mac_clear ? b_reg : w_reg[k_reg];

    perceptron_mac #(
        .WEIGHT_W (WEIGHT_W),
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (mac_clear),
        .en    (mac_en),
        .w     (mac_w),
        .x     (x_reg[k_reg]),
        .acc   (acc)
    );

`ifdef PERCEPTRON_SAT_EN
    localparam int EXT_W = WEIGHT_W + DATA_W + ETA_SHIFT + 2;
    localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
    localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
    localparam logic signed [EXT_W-1:0] W_MAX_EXT  = EXT_W'(W_MAX);
    localparam logic signed [EXT_W-1:0] W_MIN_EXT  = EXT_W'(W_MIN);
    localparam logic signed [EXT_W-1:0] B_STEP_EXT = EXT_W'(1) <<< ETA_SHIFT;

    logic [N_IN:0] sat_vec;
    logic          sat_reg;
    logic signed [EXT_W-1:0] b_sum;

    function automatic logic signed [WEIGHT_W-1:0] clamp(input logic signed [EXT_W-1:0] v);
        if (v > W_MAX_EXT) return W_MAX;
        if (v < W_MIN_EXT) return W_MIN;
        return v[WEIGHT_W-1:0];
    endfunction

    assign b_sum          = EXT_W'(b_reg) + (t_neg_reg ? -B_STEP_EXT : B_STEP_EXT);
    assign sat_vec[N_IN]  = (b_sum > W_MAX_EXT) || (b_sum < W_MIN_EXT);
    assign b_next         = clamp(b_sum);
`else
    localparam logic signed [WEIGHT_W-1:0] B_STEP = WEIGHT_W'(1) <<< ETA_SHIFT;

    assign b_next = t_neg_reg ? (b_reg - B_STEP) : (b_reg + B_STEP);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_ch
`ifdef PERCEPTRON_SAT_EN
            logic signed [EXT_W-1:0] x_ext;
            logic signed [EXT_W-1:0] w_sum;
            assign x_ext        = EXT_W'(x_reg[gi]) <<< ETA_SHIFT;
            assign w_sum        = EXT_W'(w_reg[gi]) + (t_neg_reg ? -x_ext : x_ext);
            assign sat_vec[gi]  = (w_sum > W_MAX_EXT) || (w_sum < W_MIN_EXT);
            assign w_next[gi]   = clamp(w_sum);
`else
            logic signed [WEIGHT_W-1:0] step;
            assign step       = WEIGHT_W'(x_reg[gi]) <<< ETA_SHIFT;
            assign w_next[gi] = t_neg_reg ? (w_reg[gi] - step) : (w_reg[gi] + step);
`endif
            assign w_out[gi*WEIGHT_W +: WEIGHT_W] = w_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) state_next = (n_samples == '0) ? DONE : FETCH;
            end
            FETCH: begin
                if (data_valid) begin
                    mac_clear  = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (k_reg == K_LAST) state_next = UPDATE;
            end
            UPDATE:    state_next = more_samples ? FETCH : EPOCH_END;
            EPOCH_END: state_next = (!upd_reg || epoch_limit) ? DONE : FETCH;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            idx_reg   <= '0;
            k_reg     <= '0;
            t_neg_reg <= 1'b0;
            upd_reg   <= 1'b0;
            conv_reg  <= 1'b0;
            epoch_reg <= '0;
            b_reg     <= '0;
            for (int i = 0; i < N_IN; i++) begin
                w_reg[i] <= '0;
                x_reg[i] <= '0;
            end
`ifdef PERCEPTRON_SAT_EN
            sat_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        n_reg     <= n_samples;
                        idx_reg   <= '0;
                        epoch_reg <= '0;
                        upd_reg   <= 1'b0;
                        conv_reg  <= (n_samples == '0);
                        b_reg     <= '0;
                        for (int i = 0; i < N_IN; i++) w_reg[i] <= '0;
`ifdef PERCEPTRON_SAT_EN
                        sat_reg   <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (data_valid) begin
                        for (int i = 0; i < N_IN; i++) x_reg[i] <= x_in[i*DATA_W +: DATA_W];
                        t_neg_reg <= (t_in[1] == T_NEG[1]);
                        k_reg     <= '0;
                    end
                end
                MAC: k_reg <= k_reg + K_W'(1);
                UPDATE: begin
                    if (mismatch) begin
                        for (int i = 0; i < N_IN; i++) w_reg[i] <= w_next[i];
                        b_reg   <= b_next;
                        upd_reg <= 1'b1;
`ifdef PERCEPTRON_SAT_EN
                        sat_reg <= sat_reg | (|sat_vec);
`endif
                    end
                    if (more_samples) idx_reg <= idx_reg + CNT_W'(1);
                end
                EPOCH_END: begin
                    epoch_reg <= epoch_inc;
                    if (!upd_reg) begin
`ifdef PERCEPTRON_SAT_EN
                        conv_reg <= !sat_reg;
`else
                        conv_reg <= 1'b1;
`endif
                    end else if (epoch_limit) begin
                        conv_reg <= 1'b0;
                    end else begin
                        upd_reg <= 1'b0;
                        idx_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_req    = (state_reg == FETCH);
    assign sample_idx  = idx_reg;
    assign done        = (state_reg == DONE);
    assign converged   = conv_reg;
    assign epoch_count = epoch_reg;
    assign b_out       = b_reg;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer: single-sample table, AND/XOR runs, reset abort, saturation/wrap.
module tb_perceptron_trainer;
    import perceptron_pkg::*;

    localparam int DW  = 7;
    localparam int WW  = 14;
    localparam int DWS = 8;
    localparam int WWS = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      n_samples = '0;
    logic [2*DW-1:0]  x_in = '0;
    logic [2*DWS-1:0] x_s = '0;
    logic [1:0]       t_in = T_POS;
    logic             data_valid = 1'b0;

    logic             data_req, done, converged;
    logic [31:0]      sample_idx;
    logic [7:0]       epoch_count;
    logic [2*WW-1:0]  w_out;
    logic [WW-1:0]    b_out;

    logic             data_req_s, done_s, converged_s;
    logic [31:0]      sample_idx_s;
    logic [7:0]       epoch_count_s;
    logic [2*WWS-1:0] w_out_s;
    logic [WWS-1:0]   b_out_s;

    int checks = 0;
    int failures = 0;

    int          sx0 [4];
    int          sx1 [4];
    logic [1:0]  st  [4];

    typedef struct {
        int         x0;
        int         x1;
        logic [1:0] t;
        int         w0;
        int         w1;
        int         b;
        int         ep;
        int         conv;
    } vec_t;

    vec_t vecs [6];

    perceptron_trainer #(
        .N_IN(2), .DATA_W(DW), .WEIGHT_W(WW), .ETA_SHIFT(0), .MAX_EPOCHS(8), .CNT_W(32)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .x_in(x_in), .t_in(t_in),
        .data_valid(data_valid), .data_req(data_req), .sample_idx(sample_idx), .done(done),
        .converged(converged), .epoch_count(epoch_count), .w_out(w_out), .b_out(b_out)
    );

    perceptron_trainer #(
        .N_IN(2), .DATA_W(DWS), .WEIGHT_W(WWS), .ETA_SHIFT(0), .MAX_EPOCHS(8), .CNT_W(32)
    ) dut_s (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .x_in(x_s), .t_in(t_in),
        .data_valid(data_valid), .data_req(data_req_s), .sample_idx(sample_idx_s), .done(done_s),
        .converged(converged_s), .epoch_count(epoch_count_s), .w_out(w_out_s), .b_out(b_out_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_run(input int n);
        @(negedge clk);
        n_samples = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one sample; returns on the negedge after the accepting clock edge.
    task automatic feed(input int x0, input int x1, input logic [1:0] t, input bit on_s);
        int waited = 0;
        while (!(on_s ? data_req_s : data_req) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("req_seen", on_s ? data_req_s : data_req, 1);
        x_in = {7'(x1), 7'(x0)};
        x_s  = {8'(x1), 8'(x0)};
        t_in = t;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Serve samples from sx0/sx1/st by sample_idx until done or the budget runs out.
    task automatic run_train(input int budget);
        bit finished = 1'b0;
        int i;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                finished = 1'b1;
                break;
            end
            if (data_req) begin
                i = int'(sample_idx);
                x_in = {7'(sx1[i]), 7'(sx0[i])};
                t_in = st[i];
                data_valid = 1'b1;
            end else begin
                data_valid = 1'b0;
            end
        end
        data_valid = 1'b0;
        check("train_finished", finished, 1);
    endtask

    task automatic load_set(input int a0, a1, input logic [1:0] ta, input int b0, b1, input logic [1:0] tb,
                            input int c0, c1, input logic [1:0] tc, input int d0, d1, input logic [1:0] td);
        sx0[0] = a0; sx1[0] = a1; st[0] = ta;
        sx0[1] = b0; sx1[1] = b1; st[1] = tb;
        sx0[2] = c0; sx1[2] = c1; st[2] = tc;
        sx0[3] = d0; sx1[3] = d1; st[3] = td;
    endtask

    function automatic longint w0v();
        return longint'($signed(w_out[WW-1:0]));
    endfunction
    function automatic longint w1v();
        return longint'($signed(w_out[2*WW-1:WW]));
    endfunction
    function automatic longint bv();
        return longint'($signed(b_out));
    endfunction

    initial begin
        longint net;
        int exp_w0s;

        vecs[0] = '{x0: 3,   x1: -2, t: T_POS, w0: 3,   w1: -2, b: 1, ep: 2, conv: 1};
        vecs[1] = '{x0: -64, x1: 63, t: T_POS, w0: -64, w1: 63, b: 1, ep: 2, conv: 1};
        vecs[2] = '{x0: 5,   x1: 7,  t: T_NEG, w0: 0,   w1: 0,  b: 0, ep: 1, conv: 1};
        vecs[3] = '{x0: 0,   x1: 0,  t: T_POS, w0: 0,   w1: 0,  b: 1, ep: 2, conv: 1};
        vecs[4] = '{x0: -7,  x1: -1, t: 2'b00, w0: -7,  w1: -1, b: 1, ep: 2, conv: 1};
        vecs[5] = '{x0: 10,  x1: 20, t: 2'b10, w0: 0,   w1: 0,  b: 0, ep: 1, conv: 1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_w0", w0v(), 0);
        check("rst_b", bv(), 0);
        check("rst_done", done, 0);
        check("rst_req", data_req, 0);
        check("rst_epoch", epoch_count, 0);
        rst = 1'b0;

        // Single-sample training table
        for (int v = 0; v < 6; v++) begin
            do_reset();
            sx0[0] = vecs[v].x0;
            sx1[0] = vecs[v].x1;
            st[0]  = vecs[v].t;
            start_run(1);
            run_train(100);
            check("vec_w0", w0v(), vecs[v].w0);
            check("vec_w1", w1v(), vecs[v].w1);
            check("vec_b", bv(), vecs[v].b);
            check("vec_epoch", epoch_count, vecs[v].ep);
            check("vec_conv", converged, vecs[v].conv);
            $display("vec %0d: x=(%0d,%0d) t=%b -> w=(%0d,%0d) b=%0d epochs=%0d conv=%0d",
                     v, vecs[v].x0, vecs[v].x1, vecs[v].t, w0v(), w1v(), bv(), epoch_count, converged);
        end

        // n_samples == 0: immediate convergence, then restart from DONE
        do_reset();
        @(negedge clk);
        n_samples = 0;
        start = 1'b1;
        check("n0_req_a", data_req, 0);
        @(negedge clk);
        start = 1'b0;
        check("n0_done", done, 1);
        check("n0_conv", converged, 1);
        check("n0_epoch", epoch_count, 0);
        check("n0_req_b", data_req, 0);
        @(negedge clk);
        n_samples = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_done", done, 0);
        check("restart_req", data_req, 1);
        $display("n_samples=0: done=1 conv=1, restart accepted");

        // Bipolar AND with latency and stall checks
        do_reset();
        load_set(1, 1, T_POS, 1, -1, T_NEG, -1, 1, T_NEG, -1, -1, T_NEG);
        start_run(4);
        feed(1, 1, T_POS, 1'b0);
        check("lat_mac0", data_req, 0);
        @(negedge clk);
        check("lat_mac1", data_req, 0);
        @(negedge clk);
        check("lat_update", data_req, 0);
        @(negedge clk);
        check("lat_fetch", data_req, 1);
        check("lat_idx", sample_idx, 1);
        check("and_s0_w0", w0v(), 1);
        check("and_s0_w1", w1v(), 1);
        check("and_s0_b", bv(), 1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_req", data_req, 1);
        end
        check("stall_idx", sample_idx, 1);
        check("stall_w0", w0v(), 1);
        check("stall_b", bv(), 1);
        run_train(200);
        check("and_done", done, 1);
        check("and_conv", converged, 1);
        check("and_epoch", epoch_count, 2);
        check("and_w0", w0v(), 1);
        check("and_w1", w1v(), 1);
        check("and_b", bv(), -1);
        for (int s = 0; s < 4; s++) begin
            net = w0v() * sx0[s] + w1v() * sx1[s] + bv();
            check("and_classify", (net > 0) ? 1 : 0, (st[s] == T_POS) ? 1 : 0);
        end
        $display("AND: w=(%0d,%0d) b=%0d epochs=%0d conv=%0d", w0v(), w1v(), bv(), epoch_count, converged);

        // XOR never converges
        do_reset();
        load_set(1, 1, T_NEG, 1, -1, T_POS, -1, 1, T_POS, -1, -1, T_NEG);
        start_run(4);
        run_train(400);
        check("xor_done", done, 1);
        check("xor_conv", converged, 0);
        check("xor_epoch", epoch_count, 8);
        $display("XOR: epochs=%0d conv=%0d", epoch_count, converged);

        // Reset mid-MAC after one committed update
        do_reset();
        load_set(1, 1, T_POS, 1, -1, T_NEG, -1, 1, T_NEG, -1, -1, T_NEG);
        start_run(4);
        feed(1, 1, T_POS, 1'b0);
        feed(1, -1, T_NEG, 1'b0);
        check("pre_abort_w0", w0v(), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("abort_w0", w0v(), 0);
        check("abort_w1", w1v(), 0);
        check("abort_b", bv(), 0);
        check("abort_idx", sample_idx, 0);
        check("abort_req", data_req, 0);
        check("abort_epoch", epoch_count, 0);
        @(negedge clk);
        check("abort_idle_req", data_req, 0);
        check("abort_idle_done", done, 0);
        $display("abort: outputs cleared after reset mid-MAC");

        // 8-bit weights: third update pushes w0 to 200
        do_reset();
        start_run(3);
        feed(100, 0, T_POS, 1'b1);
        feed(0, 100, T_NEG, 1'b1);
        feed(100, 100, T_POS, 1'b1);
        for (int c = 0; c < 20 && !data_req_s; c++) @(negedge clk);
        check("sat_req", data_req_s, 1);
`ifdef PERCEPTRON_SAT_EN
        exp_w0s = 127;
`else
        exp_w0s = -56;
`endif
        check("sat_w0", longint'($signed(w_out_s[WWS-1:0])), exp_w0s);
        check("sat_w1", longint'($signed(w_out_s[2*WWS-1:WWS])), 0);
        check("sat_b", longint'($signed(b_out_s)), 1);
        check("sat_epoch", epoch_count_s, 1);
        $display("8-bit: w=(%0d,%0d) b=%0d", $signed(w_out_s[WWS-1:0]), $signed(w_out_s[2*WWS-1:WWS]),
                 $signed(b_out_s));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
